// File: rtl/filter_window_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | filter_window_ctrl                                                       |
// | Frame sequencer: fetches 1 or 9 source pixels per output pixel into a    |
// | 3x3 window, then writes the datapath result to the output frame buffer.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module filter_window_ctrl #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [4:0]        filter_sel,
   output logic              busy,
   output logic              done,
   output logic [4:0]        filter,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
   output logic [23:0]       colour_i0,
   output logic [23:0]       colour_i1,
   output logic [23:0]       colour_i2,
   output logic [23:0]       colour_i3,
   output logic [23:0]       colour_i4,
   output logic [23:0]       colour_i5,
   output logic [23:0]       colour_i6,
   output logic [23:0]       colour_i7,
   output logic [23:0]       colour_i8,
   input  logic [23:0]       colour_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_data
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [XW-1:0]     C_X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0]     C_Y_LAST = YW'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] C_ROW    = ADDR_W'(WIDTH);
   localparam logic [4:0]        C_NCODES = 5'd12;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LAST  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [3:0]        r_k;
   logic [ADDR_W-1:0] r_row_base;
   logic              r_window;
   logic [4:0]        r_filter;
   logic [23:0]       r_slot [9];

   logic [3:0]        w_n_reads;
   logic              w_fetch_end;
   logic              w_last_pixel;
   logic [3:0]        w_k_sel;
   logic [XW-1:0]     w_x_lo;
   logic [XW-1:0]     w_x_hi;
   logic [XW-1:0]     w_col;
   logic [ADDR_W-1:0] w_base_up;
   logic [ADDR_W-1:0] w_base_dn;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_slot_addr;

   assign w_n_reads    = r_window ? 4'd9 : 4'd1;
   assign w_fetch_end  = (r_k == (w_n_reads - 4'd1));
   assign w_last_pixel = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

   // In LAST the counter has already moved past the final slot; the address holds on it.
   assign w_k_sel = (r_state == S_LAST) ? (r_k - 4'd1) : r_k;

   // Edge replication: neighbours beyond the frame collapse onto the border pixel.
   assign w_x_lo    = (r_x == '0)       ? r_x        : (r_x - XW'(1));
   assign w_x_hi    = (r_x == C_X_LAST) ? r_x        : (r_x + XW'(1));
   assign w_base_up = (r_y == '0)       ? r_row_base : (r_row_base - C_ROW);
   assign w_base_dn = (r_y == C_Y_LAST) ? r_row_base : (r_row_base + C_ROW);

   always_comb begin
      w_col  = r_x;
      w_base = r_row_base;
      if (r_window) begin
         case (w_k_sel)
            4'd0, 4'd3, 4'd6: w_col = w_x_lo;
            4'd2, 4'd5, 4'd8: w_col = w_x_hi;
            default:          w_col = r_x;
         endcase
         case (w_k_sel)
            4'd0, 4'd1, 4'd2: w_base = w_base_up;
            4'd6, 4'd7, 4'd8: w_base = w_base_dn;
            default:          w_base = r_row_base;
         endcase
      end
   end

   assign w_slot_addr = w_base + ADDR_W'(w_col);

   always_comb begin
      w_next  = r_state;
      busy    = 1'b1;
      done    = 1'b0;
      wr_en   = 1'b0;
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_FETCH;
         end
         S_FETCH: begin
            rd_addr = w_slot_addr;
            if (w_fetch_end) w_next = S_LAST;
         end
         S_LAST: begin
            rd_addr = w_slot_addr;
            w_next  = S_WRITE;
         end
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = r_row_base + ADDR_W'(r_x);
            wr_data = colour_out;
            w_next  = w_last_pixel ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_k        <= '0;
         r_row_base <= '0;
         r_window   <= 1'b0;
         r_filter   <= '0;
         for (int i = 0; i < 9; i++) r_slot[i] <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x        <= '0;
                  r_y        <= '0;
                  r_k        <= '0;
                  r_row_base <= '0;
                  r_filter   <= (filter_sel < C_NCODES) ? filter_sel : 5'd0;
                  r_window   <= (filter_sel >= 5'd8) && (filter_sel < C_NCODES);
               end
            end
            S_FETCH: begin
               r_k <= r_k + 4'd1;
               // RAM data lags the address by one cycle, so it belongs to slot k-1.
               for (int i = 0; i < 8; i++) begin
                  if (r_window && (r_k == 4'(i + 1))) r_slot[i] <= rd_data;
               end
            end
            S_LAST: begin
               if (r_window) begin
                  r_slot[8] <= rd_data;
               end else begin
                  for (int i = 0; i < 9; i++) r_slot[i] <= rd_data;
               end
            end
            S_WRITE: begin
               r_k <= '0;
               if (!w_last_pixel) begin
                  if (r_x == C_X_LAST) begin
                     r_x        <= '0;
                     r_y        <= r_y + YW'(1);
                     r_row_base <= r_row_base + C_ROW;
                  end else begin
                     r_x <= r_x + XW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign filter    = r_filter;
   assign colour_i0 = r_slot[0];
   assign colour_i1 = r_slot[1];
   assign colour_i2 = r_slot[2];
   assign colour_i3 = r_slot[3];
   assign colour_i4 = r_slot[4];
   assign colour_i5 = r_slot[5];
   assign colour_i6 = r_slot[6];
   assign colour_i7 = r_slot[7];
   assign colour_i8 = r_slot[8];

endmodule
`default_nettype wire

// File: tb/tb_filter_window_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_filter_window_ctrl                                                    |
// | Frame-level bench on a 4x3 frame with a behavioural address/window model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_filter_window_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 4;
   localparam int P  = W * H;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [4:0]    filter_sel = '0;
   logic          busy, done, wr_en;
   logic [4:0]    filter;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [23:0]   rd_data = '0;
   logic [23:0]   slot [9];
   logic [23:0]   colour_out;
   logic [23:0]   wr_data;
   logic [23:0]   mem [16];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] sel;
      logic [4:0] exp_filter;
      int         n;
      bit         ramp;
      bit         hold;
      bit         mid_start;
   } vec_t;

   vec_t tbl [9];
   int   first_a [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
   int   last_a  [9] = '{6, 7, 7, 10, 11, 11, 10, 11, 11};

   filter_window_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .start(start), .filter_sel(filter_sel),
      .busy(busy), .done(done), .filter(filter),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .colour_i0(slot[0]), .colour_i1(slot[1]), .colour_i2(slot[2]),
      .colour_i3(slot[3]), .colour_i4(slot[4]), .colour_i5(slot[5]),
      .colour_i6(slot[6]), .colour_i7(slot[7]), .colour_i8(slot[8]),
      .colour_out(colour_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) rd_data <= mem[rd_addr];

   // Stand-in datapath: pass-through for code 0, otherwise a weighted sum of all nine slots.
   function automatic logic [23:0] dp(input logic [4:0] f, input logic [23:0] s [9]);
      logic [23:0] acc = '0;
      if (f == 5'd0) return s[4];
      for (int i = 0; i < 9; i++) acc = acc + 24'(s[i] * (i + 1));
      return acc;
   endfunction

   always_comb colour_out = dp(filter, slot);

   function automatic int exp_addr(input int pix, input int k, input int n);
      int x, y, xx, yy;
      x = pix % W;
      y = pix / W;
      if (n == 1) return y * W + x;
      xx = x + (k % 3) - 1;
      yy = y + (k / 3) - 1;
      if (xx < 0) xx = 0;
      if (xx > W - 1) xx = W - 1;
      if (yy < 0) yy = 0;
      if (yy > H - 1) yy = H - 1;
      return yy * W + xx;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entered in an IDLE cycle (cycle 0); leaves in the IDLE cycle after DONE.
   task automatic run_frame(input vec_t v);
      int          n, len, pix, pos, wr_cnt, ka;
      logic [23:0] es [9];
      n      = v.n;
      len    = n + 2;
      wr_cnt = 0;
      for (int i = 0; i < 16; i++) mem[i] = v.ramp ? 24'(i * 32'h010101) : 24'($urandom);
      filter_sel = v.sel;
      start      = 1'b1;
      tick();
      for (int c = 1; c <= P * len + 1; c++) begin
         if (v.mid_start && c == 15) begin
            start      = 1'b1;
            filter_sel = 5'd9;
         end else begin
            start      = v.hold;
            filter_sel = 5'($urandom);
         end
         pix = (c - 1) / len;
         pos = (c - 1) % len;
         if (c == P * len + 1) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("wr_en_in_done", 32'(wr_en), 32'd0);
         end else begin
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("wr_en", 32'(wr_en), 32'(pos == n + 1));
            if (pos <= n) begin
               ka = (pos < n) ? pos : n - 1;
               chk("rd_addr", 32'(rd_addr), 32'(exp_addr(pix, ka, n)));
               if (n == 9 && pos < n && pix == 0)     chk("corner_first", 32'(rd_addr), 32'(first_a[pos]));
               if (n == 9 && pos < n && pix == P - 1) chk("corner_last", 32'(rd_addr), 32'(last_a[pos]));
            end else begin
               for (int k = 0; k < 9; k++) es[k] = mem[exp_addr(pix, k, n)];
               for (int k = 0; k < 9; k++) chk("window_slot", 32'(slot[k]), 32'(es[k]));
               chk("wr_addr", 32'(wr_addr), 32'(pix));
               chk("wr_data", 32'(wr_data), 32'(dp(v.exp_filter, es)));
               if (v.ramp) chk("passthrough", 32'(wr_data), 32'(pix * 32'h010101));
               wr_cnt++;
            end
         end
         chk("filter", 32'(filter), 32'(v.exp_filter));
         tick();
      end
      chk("write_count", 32'(wr_cnt), 32'(P));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_idle", 32'(done), 32'd0);
      chk("wr_en_idle", 32'(wr_en), 32'd0);
   endtask

   initial begin
      tbl[0] = '{sel: 5'd0,  exp_filter: 5'd0,  n: 1, ramp: 1'b1, hold: 1'b0, mid_start: 1'b0};
      tbl[1] = '{sel: 5'd8,  exp_filter: 5'd8,  n: 9, ramp: 1'b0, hold: 1'b0, mid_start: 1'b0};
      tbl[2] = '{sel: 5'd20, exp_filter: 5'd0,  n: 1, ramp: 1'b0, hold: 1'b0, mid_start: 1'b0};
      tbl[3] = '{sel: 5'd5,  exp_filter: 5'd5,  n: 1, ramp: 1'b0, hold: 1'b0, mid_start: 1'b1};
      tbl[4] = '{sel: 5'd11, exp_filter: 5'd11, n: 9, ramp: 1'b0, hold: 1'b1, mid_start: 1'b0};
      tbl[5] = '{sel: 5'd3,  exp_filter: 5'd3,  n: 1, ramp: 1'b0, hold: 1'b0, mid_start: 1'b0};
      tbl[6] = '{sel: 5'd12, exp_filter: 5'd0,  n: 1, ramp: 1'b0, hold: 1'b0, mid_start: 1'b0};
      tbl[7] = '{sel: 5'd31, exp_filter: 5'd0,  n: 1, ramp: 1'b0, hold: 1'b0, mid_start: 1'b0};
      tbl[8] = '{sel: 5'd9,  exp_filter: 5'd9,  n: 9, ramp: 1'b0, hold: 1'b0, mid_start: 1'b1};
      for (int i = 0; i < 16; i++) mem[i] = '0;

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_filter", 32'(filter), 32'd0);
      for (int k = 0; k < 9; k++) chk("rst_slot", 32'(slot[k]), 32'd0);

      for (int t = 0; t < 9; t++) run_frame(tbl[t]);

      // Reset during cycle 20 of a window frame.
      filter_sel = 5'd8;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      chk("busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("mid_rst_filter", 32'(filter), 32'd0);
      for (int k = 0; k < 9; k++) chk("mid_rst_slot", 32'(slot[k]), 32'd0);
      for (int c = 0; c < 40; c++) begin
         chk("post_rst_quiet", 32'({busy, done, wr_en}), 32'd0);
         tick();
      end
      run_frame(tbl[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
